bsm_operand_serializer: RTL
===========================

BSM_OPERAND_SERIALIZER -- requirements
Module: bsm_operand_serializer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port op_valid, input, 1 bit: the upstream operand pair is valid.
REQ-004 SHALL have port op_ready, output, 1 bit: the block accepts an operand pair.
REQ-005 SHALL have port op_a, input, 32 bits, signed: operand A.
REQ-006 SHALL have port op_b, input, 32 bits, signed: operand B.
REQ-007 SHALL have port op_wa, input, 5 bits: width of A.
REQ-008 SHALL have port op_wb, input, 5 bits: width of B.
REQ-009 SHALL have port bsm_start, output, 1 bit: start pulse to the bit-serial multiplier.
REQ-010 SHALL have port bsm_bit_a, output, 1 bit: serial bit of A, LSB first.
REQ-011 SHALL have port bsm_bit_b, output, 1 bit: serial bit of B, LSB first.
REQ-012 SHALL have port bsm_o, input, 32 bits, signed: product from the multiplier.
REQ-013 SHALL have port bsm_done, input, 1 bit: product valid.
REQ-014 SHALL have port res_valid, output, 1 bit: result available.
REQ-015 SHALL have port res_ready, input, 1 bit: downstream accepts the result.
REQ-016 SHALL have port res_data, output, 32 bits, signed: captured product.
REQ-017 SHALL have port res_err, output, 1 bit: the result is invalid (bad width or timeout).

Function
REQ-018 SHALL implement the states IDLE, SHIFT, WAIT_DONE and RESULT.
REQ-019 SHALL assert op_ready only in IDLE; an op_valid&&op_ready edge SHALL capture op_a, op_b, op_wa and op_wb.
REQ-020 SHALL treat widths 2..16 as legal; if either captured width is illegal, the block SHALL skip SHIFT, go directly to RESULT with res_data=0 and res_err=1, and issue no bsm_start.
REQ-021 SHALL, on a legal accept, enter SHIFT and assert bsm_start for exactly the first SHIFT cycle, with bit index 0 on bsm_bit_a and bsm_bit_b in that cycle.
REQ-022 SHALL present bit index i in the i-th cycle after bsm_start, for i = 0,1,2...
REQ-023 SHALL, for bit index >= the operand's width, drive that operand's bit W-1 (sign extension).
REQ-024 SHALL keep serial output bits valid in WAIT_DONE, continuing the sign extension.
REQ-025 SHALL leave SHIFT for WAIT_DONE after max(WA,WB) bits.
REQ-026 SHALL, in SHIFT or WAIT_DONE, capture bsm_o into res_data with res_err=0 on the first bsm_done, then go to RESULT.
REQ-027 SHALL count cycles from bsm_start; if bsm_done is not seen within WA+WB+4 cycles, go to RESULT with res_data=0 and res_err=1.
REQ-028 SHALL hold res_valid in RESULT with res_data and res_err stable until res_valid&&res_ready, then return to IDLE.
REQ-029 SHALL NOT accept op_valid in the same cycle as a RESULT handshake; the earliest next accept is the following cycle.
REQ-030 SHALL ignore bsm_done while in IDLE or RESULT.
REQ-031 SHALL keep bsm_start low outside its one defined cycle.
REQ-032 SHALL drive bsm_bit_a and bsm_bit_b to 0 in IDLE and RESULT.
REQ-033 SHALL compute the bit index and timeout counter as unsigned 6-bit values; neither SHALL wrap within a legal run.

Reset
REQ-034 SHALL, on rst_n low, immediately set the state to IDLE and set op_ready=1, bsm_start=0, bsm_bit_a=0, bsm_bit_b=0, res_valid=0, res_data=0, res_err=0 and all counters to 0.
REQ-035 SHALL, on reset mid-operation, discard the operation with no result produced; the operation SHALL NOT resume after reset.
REQ-036 SHALL honour reset release on the first rising clock edge with rst_n high.

Structure
REQ-037 SHALL place the state enum, the constants BSM_W_MIN=2, BSM_W_MAX=16 and BSM_TO_SLACK=4, and the 32-bit data width in the shared package bsm_pkg.
REQ-038 SHALL use a single sub-module, bsm_bit_shifter, that holds one operand and its width and yields the current sign-extended bit; it SHALL be instantiated twice.

Verification
REQ-039 SHALL cover: A=15, B=-7, WA=14, WB=15, with a behavioural multiplier model -> bsm_start for exactly 1 cycle; 15 bits serialized; res_data=-105, res_err=0.
REQ-040 SHALL cover: A=-1, B=-1, WA=WB=2 -> bit streams 1,1 then sign-extended 1s; res_data=1.
REQ-041 SHALL cover: WA=1, WB=8 -> no bsm_start; res_valid with res_err=1 and res_data=0 one cycle after accept.
REQ-042 SHALL cover: model never asserts bsm_done, WA=WB=8 -> res_err=1 after 20 cycles from bsm_start.
REQ-043 SHALL cover: res_ready held low 10 cycles -> res_valid and res_data stable; op_ready=0 throughout.
REQ-044 SHALL cover: rst_n low during SHIFT at bit 5 -> outputs return to reset values asynchronously; the next op runs cleanly.

Source files
------------

// File: rtl/bsm_pkg.sv
// bsm_pkg: shared types and constants for the bit-serial multiplier operand serializer
package bsm_pkg;
  localparam int DW = 32;
  localparam logic [4:0] BSM_W_MIN = 5'd2;
  localparam logic [4:0] BSM_W_MAX = 5'd16;
  localparam logic [5:0] BSM_TO_SLACK = 6'd4;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DONE, RESULT} state_t;
  function automatic logic w_legal(input logic [4:0] w);
    return w >= BSM_W_MIN && w <= BSM_W_MAX;
  endfunction
endpackage

// File: rtl/bsm_bit_shifter.sv
// bsm_bit_shifter: holds one operand and its width, yields the sign-extended bit at idx
module bsm_bit_shifter import bsm_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [DW-1:0] d,
  input  logic [4:0]    w,
  input  logic [5:0]    idx,
  input  logic          en,
  output logic          b,
  output logic [4:0]    wq
);
  logic [DW-1:0] op;
  // capture operand and width on accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= '0;
      wq <= '0;
    end else if (ld) begin
      op <= d;
      wq <= w;
    end
  // past the width, keep repeating the top bit of the operand
  always_comb b = en && (({1'b0, wq} > idx) ? op[idx[4:0]] : op[wq - 5'd1]);
endmodule

// File: rtl/bsm_operand_serializer.sv
// bsm_operand_serializer: feeds operand pairs LSB-first to a bit-serial multiplier and returns the product
module bsm_operand_serializer import bsm_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic signed [DW-1:0] op_a,
  input  logic signed [DW-1:0] op_b,
  input  logic [4:0]           op_wa,
  input  logic [4:0]           op_wb,
  output logic                 bsm_start,
  output logic                 bsm_bit_a,
  output logic                 bsm_bit_b,
  input  logic signed [DW-1:0] bsm_o,
  input  logic                 bsm_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [DW-1:0] res_data,
  output logic                 res_err
);
  state_t state;
  logic [5:0] cnt, mx_last, to_last;
  logic [4:0] wa, wb;
  logic acc, en;
  // cnt is both the bit index and the cycles-since-start counter
  always_comb begin
    acc = op_valid && op_ready;
    en = state == SHIFT || state == WAIT_DONE;
    mx_last = (wa > wb ? {1'b0, wa} : {1'b0, wb}) - 6'd1;
    to_last = {1'b0, wa} + {1'b0, wb} + BSM_TO_SLACK - 6'd1;
    op_ready = state == IDLE;
    bsm_start = state == SHIFT && cnt == 6'd0;
    res_valid = state == RESULT;
  end
  bsm_bit_shifter u_a (.clk(clk), .rst_n(rst_n), .ld(acc), .d(op_a), .w(op_wa), .idx(cnt), .en(en), .b(bsm_bit_a), .wq(wa));
  bsm_bit_shifter u_b (.clk(clk), .rst_n(rst_n), .ld(acc), .d(op_b), .w(op_wb), .idx(cnt), .en(en), .b(bsm_bit_b), .wq(wb));
  // control FSM; bad widths bypass the multiplier, done beats the timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      res_data <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (op_valid) begin
            cnt <= '0;
            if (w_legal(op_wa) && w_legal(op_wb)) state <= SHIFT;
            else begin
              state <= RESULT;
              res_data <= '0;
              res_err <= 1'b1;
            end
          end
        SHIFT, WAIT_DONE: begin
          cnt <= cnt + 6'd1;
          if (bsm_done) begin
            state <= RESULT;
            res_data <= bsm_o;
            res_err <= 1'b0;
          end else if (cnt == to_last) begin
            state <= RESULT;
            res_data <= '0;
            res_err <= 1'b1;
          end else if (state == SHIFT && cnt == mx_last) state <= WAIT_DONE;
        end
        RESULT: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
